// File: rtl/m68k_bus_pkg.sv
// Shared constants for the 68000 bus master: FSM state codes,
// function codes and the legal E-clock parameter ranges.
package m68k_bus_pkg;

    // FSM states: S0..S7 follow the 68000 half-state names, GRANT
    // is the bus-arbitration hold-off.
    localparam logic [3:0] ST_S0    = 4'd0;
    localparam logic [3:0] ST_S1    = 4'd1;
    localparam logic [3:0] ST_S2    = 4'd2;
    localparam logic [3:0] ST_S3    = 4'd3;
    localparam logic [3:0] ST_S4    = 4'd4;
    localparam logic [3:0] ST_S5    = 4'd5;
    localparam logic [3:0] ST_S6    = 4'd6;
    localparam logic [3:0] ST_S7    = 4'd7;
    localparam logic [3:0] ST_GRANT = 4'd8;

    localparam logic [2:0] FC_IACK = 3'b111;

    // E-clock divider limits and counter width
    localparam int E_DIV_MIN  = 6;
    localparam int E_DIV_MAX  = 16;
    localparam int E_HIGH_MIN = 2;
    localparam int ECW        = 4;

    // S4 wait-state counter width
    localparam int WCW = 16;

endpackage

// File: rtl/m68k_bus_master_eclock.sv
// 6800-style E clock and VMA generator for the 68000 bus master.
// Ports: clk/reset_n, phi1/phi2 enables, busy (cycle or grant in
// progress), vpa_n in; e, vma_n, count (E phase), vpa_low out.
module m68k_bus_master_eclock
    import m68k_bus_pkg::*;
#(
    parameter int E_DIV  = 10,
    parameter int E_HIGH = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           phi1,
    input  logic           phi2,
    input  logic           busy,
    input  logic           vpa_n,
    output logic           e,
    output logic           vma_n,
    output logic [ECW-1:0] count,
    output logic           vpa_low
);

    localparam logic [ECW-1:0] C_LAST = ECW'(E_DIV - 1);
    localparam logic [ECW-1:0] C_RISE = ECW'(E_DIV - E_HIGH - 1);
    localparam logic [ECW-1:0] C_HI   = ECW'(E_DIV - 2);
    localparam logic [ECW-1:0] C_VMA  = ECW'(E_DIV - E_HIGH - 3);

    logic           p2;
    logic [ECW-1:0] cnt_nxt;

    // phi1 wins when both enables are high
    assign p2      = phi2 & ~phi1;
    assign cnt_nxt = (count == C_LAST) ? '0 : count + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count   <= '0;
            e       <= 1'b0;
            vma_n   <= 1'b1;
            vpa_low <= 1'b0;
        end else if (phi1) begin
            vpa_low <= ~vpa_n;
            if (count == '0)
                vma_n <= 1'b1;
        end else if (p2) begin
            count <= cnt_nxt;
            // E is high while the counter sits in [C_RISE, C_HI]
            e     <= (cnt_nxt >= C_RISE) && (cnt_nxt <= C_HI);
            if (busy && vpa_low && count == C_VMA)
                vma_n <= 1'b0;
        end
    end

endmodule

// File: rtl/m68k_bus_master.sv
// 68000 asynchronous bus master: req/ack core side to AS/UDS/LDS/RW
// bus side, with BR/BG/BGACK arbitration, E/VMA and autovectors.
// Ports: core req/we/be/fc_in/a_in/wdata -> ack/err/rdata; bus
// addr/dout/din/fc/strobes/terminations; E, vma_n; br/bg/bgack, bus_oe.
module m68k_bus_master
    import m68k_bus_pkg::*;
#(
    parameter int         AW            = 24,
    parameter int         E_DIV         = 10,
    parameter int         E_HIGH        = 4,
    parameter int         DTACK_TIMEOUT = 0,
    parameter logic [7:0] AUTOVEC_BASE  = 8'h18
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          phi1,
    input  logic          phi2,
    input  logic          req,
    input  logic          we,
    input  logic [1:0]    be,
    input  logic [2:0]    fc_in,
    input  logic [AW-1:0] a_in,
    input  logic [15:0]   wdata,
    output logic          ack,
    output logic          err,
    output logic [15:0]   rdata,
    output logic [AW-1:0] addr,
    output logic [15:0]   dout,
    input  logic [15:0]   din,
    output logic [2:0]    fc,
    output logic          as_n,
    output logic          uds_n,
    output logic          lds_n,
    output logic          rw_n,
    input  logic          dtack_n,
    input  logic          berr_n,
    input  logic          vpa_n,
    output logic          E,
    output logic          vma_n,
    input  logic          br_n,
    input  logic          bgack_n,
    output logic          bg_n,
    output logic          bus_oe
);

    if (E_DIV < E_DIV_MIN || E_DIV > E_DIV_MAX ||
        E_HIGH < E_HIGH_MIN || E_HIGH > E_DIV - 2) begin : g_bad_param
        $error("m68k_bus_master: E_DIV/E_HIGH out of range");
    end

    localparam logic [ECW-1:0] VMA_END = ECW'(E_DIV - 2);
    localparam logic [WCW-1:0] TO_LAST =
        (DTACK_TIMEOUT == 0) ? '0 : WCW'(DTACK_TIMEOUT - 1);

    logic [3:0]     state;
    logic [WCW-1:0] wcnt;
    logic           err_q;
    logic           we_q;
    logic [1:0]     be_q;
    logic           bgack_seen;
    logic           p2;
    logic [ECW-1:0] ecount;
    logic           vpa_low;
    logic           vma_done;
    logic           to_hit;
    logic [7:0]     vec;

    assign p2 = phi2 & ~phi1;

    assign vma_done = ~vma_n && (ecount == VMA_END);

    // A VPA-terminated cycle is legitimately long; the DTACK
    // watchdog only runs while no VPA response is pending.
    assign to_hit = (DTACK_TIMEOUT != 0) && ~vpa_low &&
                    (wcnt == TO_LAST);

    assign vec = AUTOVEC_BASE + {5'd0, addr[3:1]};

    m68k_bus_master_eclock #(
        .E_DIV  (E_DIV),
        .E_HIGH (E_HIGH)
    ) u_eclock (
        .clk     (clk),
        .reset_n (reset_n),
        .phi1    (phi1),
        .phi2    (phi2),
        .busy    (state != ST_S0),
        .vpa_n   (vpa_n),
        .e       (E),
        .vma_n   (vma_n),
        .count   (ecount),
        .vpa_low (vpa_low)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_S0;
            wcnt       <= '0;
            err_q      <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= 2'b00;
            bgack_seen <= 1'b0;
            ack        <= 1'b0;
            err        <= 1'b0;
            rdata      <= '0;
            addr       <= '0;
            dout       <= '0;
            fc         <= '0;
            as_n       <= 1'b1;
            uds_n      <= 1'b1;
            lds_n      <= 1'b1;
            rw_n       <= 1'b1;
            bg_n       <= 1'b1;
            bus_oe     <= 1'b1;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            if (phi1) begin
                case (state)
                    ST_S0: begin
                        if (!br_n) begin
                            state <= ST_GRANT;
                        end else if (req) begin
                            addr  <= a_in;
                            dout  <= wdata;
                            fc    <= fc_in;
                            we_q  <= we;
                            be_q  <= be;
                            state <= ST_S1;
                        end
                    end
                    ST_S1: begin
                        as_n  <= 1'b0;
                        rw_n  <= ~we_q;
                        wcnt  <= '0;
                        err_q <= 1'b0;
                        if (!we_q)
                            {uds_n, lds_n} <= ~be_q;
                        state <= ST_S2;
                    end
                    ST_S3: begin
                        // write strobes wait until data is on the bus
                        if (we_q)
                            {uds_n, lds_n} <= ~be_q;
                        state <= ST_S4;
                    end
                    ST_S5: state <= ST_S6;
                    ST_S7: begin
                        ack   <= 1'b1;
                        err   <= err_q;
                        rw_n  <= 1'b1;
                        state <= ST_S0;
                    end
                    ST_GRANT: begin
                        if (!bgack_n) begin
                            bgack_seen <= 1'b1;
                            bus_oe     <= 1'b0;
                        end else if (bgack_seen) begin
                            bgack_seen <= 1'b0;
                            bus_oe     <= 1'b1;
                            state      <= ST_S0;
                        end else if (br_n) begin
                            // requester withdrew before taking the bus
                            bg_n  <= 1'b1;
                            state <= ST_S0;
                        end
                    end
                    default: ;
                endcase
            end else if (p2) begin
                case (state)
                    ST_S2: state <= ST_S3;
                    ST_S4: begin
                        if (!berr_n) begin
                            err_q <= 1'b1;
                            state <= ST_S5;
                        end else if (!dtack_n || vma_done) begin
                            state <= ST_S5;
                        end else if (to_hit) begin
                            err_q <= 1'b1;
                            state <= ST_S5;
                        end else if (!vpa_low) begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                    ST_S6: begin
                        if (fc == FC_IACK && !vpa_n)
                            rdata <= {vec, vec};
                        else
                            rdata <= din;
                        as_n  <= 1'b1;
                        uds_n <= 1'b1;
                        lds_n <= 1'b1;
                        state <= ST_S7;
                    end
                    ST_GRANT: bg_n <= bgack_seen;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_m68k_bus_master.sv
// Directed self-checking bench for m68k_bus_master.
// Half-state counter hs is 0 at the phi1 edge that accepts req.
module tb_m68k_bus_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        phi1, phi2;
    logic        req, we;
    logic [1:0]  be;
    logic [2:0]  fc_in;
    logic [23:0] a_in;
    logic [15:0] wdata, din;
    logic        ack, err;
    logic [15:0] rdata, dout;
    logic [23:0] addr;
    logic [2:0]  fc;
    logic        as_n, uds_n, lds_n, rw_n;
    logic        dtack_n, berr_n, vpa_n;
    logic        E, vma_n;
    logic        br_n, bgack_n, bg_n, bus_oe;

    logic [1:0]  pc = 2'd0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          hs;
    int          ecm;

    always #5 clk = ~clk;

    // phi1 is seen at the edge ending pc==0, phi2 at pc==2
    always @(posedge clk) pc <= pc + 2'd1;
    assign phi1 = (pc == 2'd0);
    assign phi2 = (pc == 2'd2);

    m68k_bus_master #(
        .AW            (24),
        .E_DIV         (10),
        .E_HIGH        (4),
        .DTACK_TIMEOUT (4),
        .AUTOVEC_BASE  (8'h18)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .phi1    (phi1),
        .phi2    (phi2),
        .req     (req),
        .we      (we),
        .be      (be),
        .fc_in   (fc_in),
        .a_in    (a_in),
        .wdata   (wdata),
        .ack     (ack),
        .err     (err),
        .rdata   (rdata),
        .addr    (addr),
        .dout    (dout),
        .din     (din),
        .fc      (fc),
        .as_n    (as_n),
        .uds_n   (uds_n),
        .lds_n   (lds_n),
        .rw_n    (rw_n),
        .dtack_n (dtack_n),
        .berr_n  (berr_n),
        .vpa_n   (vpa_n),
        .E       (E),
        .vma_n   (vma_n),
        .br_n    (br_n),
        .bgack_n (bgack_n),
        .bg_n    (bg_n),
        .bus_oe  (bus_oe)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance to 1 time unit after the next phi1/phi2 edge
    task automatic half();
        do begin
            @(posedge clk);
            #1;
        end while (!(pc == 2'd1 || pc == 2'd3));
        hs++;
        if (pc == 2'd3 && reset_n)
            ecm = (ecm == 9) ? 0 : ecm + 1;
    endtask

    task automatic to_phi2();
        do half(); while (pc != 2'd3);
    endtask

    task automatic wait_ack(input string tag, input int exp_hs);
        int g;
        g = 0;
        while (!ack && g < 100) begin
            half();
            g++;
        end
        chk({tag, " ack time"}, 32'(hs), 32'(exp_hs));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        req = 0; we = 0; be = 2'b00; fc_in = 3'b000;
        a_in = '0; wdata = '0; din = '0;
        dtack_n = 1; berr_n = 1; vpa_n = 1;
        br_n = 1; bgack_n = 1;
        ecm = 0; hs = 0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst strobes", 32'({as_n, uds_n, lds_n, rw_n}), 32'hF);
        chk("rst vma/bg", 32'({vma_n, bg_n, bus_oe}), 32'h7);
        chk("rst E/ack/err", 32'({E, ack, err}), 32'h0);
        chk("rst addr", 32'(addr), 32'h0);
        chk("rst rdata", 32'(rdata), 32'h0);
        reset_n = 1'b1;

        // word read, zero waits
        to_phi2();
        req = 1; we = 0; be = 2'b11; fc_in = 3'b101;
        a_in = 24'h000400; dtack_n = 0; din = 16'hBEEF; hs = -1;
        half();
        chk("rd addr", 32'(addr), 32'h400);
        chk("rd as_n t0", 32'(as_n), 32'h1);
        half(); half();
        chk("rd strobes t2", 32'({as_n, uds_n, lds_n, rw_n}), 32'h1);
        wait_ack("rd", 8);
        chk("rd err", 32'(err), 32'h0);
        chk("rd rdata", 32'(rdata), 32'hBEEF);
        chk("rd as_n end", 32'(as_n), 32'h1);
        req = 0;
        @(posedge clk); #1;
        chk("rd ack width", 32'(ack), 32'h0);

        // lower-byte write, DTACK on 4th S4 sample (ties timeout)
        to_phi2();
        req = 1; we = 1; be = 2'b01; wdata = 16'h00A5;
        a_in = 24'h000802; dtack_n = 1; hs = -1;
        half(); half();
        dtack_n = 0;
        half();
        chk("wr strobes t2", 32'({as_n, uds_n, lds_n, rw_n}), 32'h6);
        chk("wr dout", 32'(dout), 32'h00A5);
        half();
        dtack_n = 1;
        half();
        chk("wr strobes t4", 32'({as_n, uds_n, lds_n}), 32'h2);
        while (hs < 9) half();
        dtack_n = 0;
        wait_ack("wr", 14);
        chk("wr err", 32'(err), 32'h0);
        req = 0; dtack_n = 1; we = 0;

        // DTACK timeout after 4 samples
        to_phi2();
        req = 1; be = 2'b11; a_in = 24'h001000; hs = -1;
        wait_ack("to", 14);
        chk("to err", 32'(err), 32'h1);
        req = 0;
        @(posedge clk); #1;
        chk("to err width", 32'(err), 32'h0);

        // bus error on the 2nd S4 sample
        to_phi2();
        req = 1; hs = -1;
        while (hs < 5) half();
        berr_n = 0;
        wait_ack("berr", 10);
        chk("berr err", 32'(err), 32'h1);
        berr_n = 1; req = 0;

        // IACK autovector via VPA/VMA, level 5
        do half(); while (!(pc == 2'd3 && ecm == 0));
        req = 1; fc_in = 3'b111; a_in = 24'h00000A;
        vpa_n = 0; din = 16'h5555; hs = -1;
        while (hs < 5) half();
        chk("iack vma t5", 32'(vma_n), 32'h1);
        chk("iack E t5", 32'(E), 32'h0);
        while (hs < 7) half();
        chk("iack vma t7", 32'(vma_n), 32'h0);
        while (hs < 11) half();
        chk("iack E t11", 32'(E), 32'h1);
        wait_ack("iack", 20);
        chk("iack err", 32'(err), 32'h0);
        chk("iack rdata", 32'(rdata), 32'h1D1D);
        chk("iack vma end", 32'(vma_n), 32'h1);
        req = 0; vpa_n = 1; fc_in = 3'b101;

        // arbitration with pending req
        to_phi2();
        req = 1; a_in = 24'h002000; dtack_n = 0;
        din = 16'h1234; br_n = 0; hs = -1;
        half();
        chk("arb bg t0", 32'(bg_n), 32'h1);
        half();
        chk("arb bg t1", 32'({bg_n, bus_oe}), 32'h1);
        bgack_n = 0; br_n = 1;
        half();
        chk("arb oe t2", 32'({bus_oe, as_n}), 32'h1);
        half();
        chk("arb bg t3", 32'(bg_n), 32'h1);
        bgack_n = 1;
        half();
        chk("arb oe t4", 32'(bus_oe), 32'h1);
        wait_ack("arb", 14);
        chk("arb rdata", 32'(rdata), 32'h1234);
        req = 0;

        // BR pulse without BGACK
        to_phi2();
        req = 1; din = 16'h4321; br_n = 0; hs = -1;
        half(); half();
        chk("brp bg t1", 32'(bg_n), 32'h0);
        br_n = 1;
        half();
        chk("brp bg t2", 32'({bg_n, bus_oe}), 32'h3);
        wait_ack("brp", 12);
        chk("brp rdata", 32'(rdata), 32'h4321);
        req = 0;

        // asynchronous reset while waiting in S4
        to_phi2();
        req = 1; dtack_n = 1; a_in = 24'h003000; hs = -1;
        while (hs < 5) half();
        chk("rst4 as_n pre", 32'({as_n, uds_n, lds_n}), 32'h0);
        #1;
        reset_n = 0;
        #1;
        chk("rst4 strobes", 32'({as_n, uds_n, lds_n}), 32'h7);
        chk("rst4 E/ack", 32'({E, ack}), 32'h0);
        ecm = 0; req = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst4 ack hold", 32'(ack), 32'h0);
        reset_n = 1;
        dtack_n = 0; din = 16'hCAFE;
        to_phi2();
        req = 1; hs = -1;
        wait_ack("post rst", 8);
        chk("post rst rdata", 32'(rdata), 32'hCAFE);
        chk("post rst err", 32'(err), 32'h0);
        req = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
